txll_framer: RTL and testbench

- Transmit-side link-layer framer; mirror of the receive path.
- The host writes FIS words, tagged with sof/eof, into an internal synchronous buffer.
- Once at least one complete frame is buffered, the framer streams it to the link layer on the trn_t* interface using a src_rdy/dst_rdy handshake.
- Supports link-side discontinue (drop rest of frame) and host-side flush.

---
 rtl/txll_pkg.sv | 7 +
 rtl/txll_sfifo.sv | 40 ++++
 rtl/txll_framer.sv | 97 +++++++++
 tb/tb_txll_framer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/txll_pkg.sv
// txll_pkg: shared state encoding and buffer entry layout for the transmit framer.
package txll_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DRAIN} txll_state_t;
   localparam int TXLL_ENTRY_W = 34;
   localparam int TXLL_SOF_BIT = 33;
   localparam int TXLL_EOF_BIT = 32;
endpackage

// File: rtl/txll_sfifo.sv
// txll_sfifo: single-clock show-ahead FIFO with occupancy count and synchronous flush.
module txll_sfifo #(
   parameter int DEPTH_LOG2 = 5,
   parameter int WIDTH      = 34
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic do_wr, do_rd;
   assign full    = count == (DEPTH_LOG2+1)'(DEPTH);
   assign empty   = count == '0;
   assign do_wr   = wr_en & ~full;
   assign do_rd   = rd_en & ~empty;
   assign rd_data = mem[rd_ptr];
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + DEPTH_LOG2'(do_wr);
         rd_ptr <= rd_ptr + DEPTH_LOG2'(do_rd);
         count  <= count + (DEPTH_LOG2+1)'(do_wr) - (DEPTH_LOG2+1)'(do_rd);
      end
   end
   always_ff @(posedge clk) begin
      if (do_wr && !flush) mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/txll_framer.sv
// txll_framer: buffers host FIS words and streams complete frames to the link layer,
// handling link discontinue (drain rest of frame) and host flush.
module txll_framer
   import txll_pkg::*;
#(
   parameter int C_DEPTH_LOG2   = 5,
   parameter int C_AFULL_MARGIN = 4
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic [31:0]             txfifo_data,
   input  logic                    txfifo_sof,
   input  logic                    txfifo_eof,
   input  logic                    txfifo_wr_en,
   input  logic                    txfifo_flush,
   output logic                    txfifo_full,
   output logic                    txfifo_almost_full,
   output logic [C_DEPTH_LOG2:0]   txfifo_count,
   output logic                    txfifo_eof_rdy,
   output logic                    txfifo_err,
   output logic [31:0]             trn_td,
   output logic                    trn_tsof_n,
   output logic                    trn_teof_n,
   output logic                    trn_tsrc_rdy_n,
   output logic                    trn_tsrc_dsc_n,
   input  logic                    trn_tdst_rdy_n,
   input  logic                    trn_tdst_dsc_n,
   output logic                    tx_done,
   output logic                    tx_abort
);
   localparam int CW    = C_DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << C_DEPTH_LOG2;
   txll_state_t state, state_next;
   logic [TXLL_ENTRY_W-1:0] head;
   logic [CW-1:0] frame_cnt;
   logic wr_in_frame, fifo_full, fifo_empty;
   logic legal, wr_ok, src_rdy, dsc, xfer, pop, eof_popped, eof_pushed;
   logic err_q, done_q, abort_q, dsc_q;
   txll_sfifo #(.DEPTH_LOG2(C_DEPTH_LOG2), .WIDTH(TXLL_ENTRY_W)) u_fifo (
      .clk(sys_clk),
      .rst_n(sys_rst_n),
      .flush(txfifo_flush),
      .wr_en(wr_ok),
      .wr_data({txfifo_sof, txfifo_eof, txfifo_data}),
      .rd_en(pop),
      .rd_data(head),
      .count(txfifo_count),
      .full(fifo_full),
      .empty(fifo_empty)
   );
   // A sof must open a frame and a non-sof word must continue one.
   assign legal      = txfifo_sof ? ~wr_in_frame : wr_in_frame;
   assign wr_ok      = txfifo_wr_en & ~txfifo_flush & ~fifo_full & legal;
   assign eof_pushed = wr_ok & txfifo_eof;
   assign src_rdy    = (state == ST_SEND) & ~fifo_empty;
   assign dsc        = (state == ST_SEND) & ~trn_tdst_dsc_n;
   assign xfer       = src_rdy & ~trn_tdst_rdy_n & trn_tdst_dsc_n;
   assign pop        = xfer | ((state == ST_DRAIN) & ~fifo_empty);
   assign eof_popped = pop & head[TXLL_EOF_BIT];
   always_comb begin
      state_next = state;
      if (txfifo_flush) state_next = ST_IDLE;
      else if (state == ST_IDLE) state_next = (frame_cnt != '0) ? ST_SEND : ST_IDLE;
      else if (dsc) state_next = ST_DRAIN;
      else if (eof_popped) state_next = ST_IDLE;
   end
   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state       <= ST_IDLE;
         wr_in_frame <= 1'b0;
         frame_cnt   <= '0;
         err_q       <= 1'b0;
         done_q      <= 1'b0;
         abort_q     <= 1'b0;
         dsc_q       <= 1'b0;
      end else begin
         state       <= state_next;
         wr_in_frame <= txfifo_flush ? 1'b0 : wr_ok ? ~txfifo_eof : wr_in_frame;
         frame_cnt   <= txfifo_flush ? '0 : frame_cnt + CW'(eof_pushed) - CW'(eof_popped);
         err_q       <= txfifo_wr_en & ~txfifo_flush & ~wr_ok;
         done_q      <= xfer & head[TXLL_EOF_BIT] & ~txfifo_flush;
         abort_q     <= dsc & ~txfifo_flush;
         dsc_q       <= txfifo_flush & (state == ST_SEND);
      end
   end
   assign trn_td             = src_rdy ? head[31:0] : '0;
   assign trn_tsof_n         = ~(src_rdy & head[TXLL_SOF_BIT]);
   assign trn_teof_n         = ~(src_rdy & head[TXLL_EOF_BIT]);
   assign trn_tsrc_rdy_n     = ~src_rdy;
   assign trn_tsrc_dsc_n     = ~dsc_q;
   assign txfifo_full        = fifo_full;
   assign txfifo_almost_full = (CW'(DEPTH) - txfifo_count) <= CW'(C_AFULL_MARGIN);
   assign txfifo_eof_rdy     = frame_cnt != '0;
   assign txfifo_err         = err_q;
   assign tx_done            = done_q;
   assign tx_abort           = abort_q;
endmodule

// File: tb/tb_txll_framer.sv
// tb_txll_framer: directed stimulus with a queue-based reference model checked every cycle.
module tb_txll_framer;
   logic sys_clk = 0, sys_rst_n = 0;
   logic [31:0] txfifo_data = 0;
   logic txfifo_sof = 0, txfifo_eof = 0, txfifo_wr_en = 0, txfifo_flush = 0;
   logic trn_tdst_rdy_n = 0, trn_tdst_dsc_n = 1;
   logic txfifo_full, txfifo_almost_full, txfifo_eof_rdy, txfifo_err;
   logic [5:0] txfifo_count;
   logic [31:0] trn_td;
   logic trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n, trn_tsrc_dsc_n, tx_done, tx_abort;

   always #5 sys_clk = ~sys_clk;

   txll_framer dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .txfifo_data(txfifo_data), .txfifo_sof(txfifo_sof), .txfifo_eof(txfifo_eof),
      .txfifo_wr_en(txfifo_wr_en), .txfifo_flush(txfifo_flush),
      .txfifo_full(txfifo_full), .txfifo_almost_full(txfifo_almost_full),
      .txfifo_count(txfifo_count), .txfifo_eof_rdy(txfifo_eof_rdy), .txfifo_err(txfifo_err),
      .trn_td(trn_td), .trn_tsof_n(trn_tsof_n), .trn_teof_n(trn_teof_n),
      .trn_tsrc_rdy_n(trn_tsrc_rdy_n), .trn_tsrc_dsc_n(trn_tsrc_dsc_n),
      .trn_tdst_rdy_n(trn_tdst_rdy_n), .trn_tdst_dsc_n(trn_tdst_dsc_n),
      .tx_done(tx_done), .tx_abort(tx_abort)
   );

   int checks = 0, errors = 0;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: buffered words as a queue, link side as idle/sending/draining.
   logic [33:0] mq[$];
   bit m_in_frame = 0, m_err = 0, m_done = 0, m_abort = 0, m_dsc = 0;
   int m_mode = 0;
   logic [33:0] xlog[$];
   int n_done = 0, n_abort = 0, n_err = 0, n_dsc = 0;

   function automatic int m_frames();
      int n = 0;
      foreach (mq[i]) if (mq[i][32]) n++;
      return n;
   endfunction

   initial begin
      bit snd, ok;
      int ps, nf;
      logic [33:0] h, w;
      forever begin
         @(negedge sys_clk);
         snd = (m_mode == 1) && (mq.size() > 0);
         h = snd ? mq[0] : '0;
         chk("tsrc_rdy_n", trn_tsrc_rdy_n, !snd);
         chk("td", trn_td, h[31:0]);
         chk("tsof_n", trn_tsof_n, !h[33]);
         chk("teof_n", trn_teof_n, !h[32]);
         chk("tsrc_dsc_n", trn_tsrc_dsc_n, !m_dsc);
         chk("count", txfifo_count, mq.size());
         chk("full", txfifo_full, mq.size() == 32);
         chk("almost_full", txfifo_almost_full, (32 - mq.size()) <= 4);
         chk("eof_rdy", txfifo_eof_rdy, m_frames() != 0);
         chk("err", txfifo_err, m_err);
         chk("tx_done", tx_done, m_done);
         chk("tx_abort", tx_abort, m_abort);
         if (!trn_tsrc_rdy_n && !trn_tdst_rdy_n && trn_tdst_dsc_n)
            xlog.push_back({~trn_tsof_n, ~trn_teof_n, trn_td});
         n_done += int'(tx_done);
         n_abort += int'(tx_abort);
         n_err += int'(txfifo_err);
         n_dsc += int'(!trn_tsrc_dsc_n);
         if (!sys_rst_n) begin
            mq.delete(); m_in_frame = 0; m_mode = 0;
            m_err = 0; m_done = 0; m_abort = 0; m_dsc = 0;
         end else if (txfifo_flush) begin
            m_dsc = (m_mode == 1);
            mq.delete(); m_in_frame = 0; m_mode = 0;
            m_err = 0; m_done = 0; m_abort = 0;
         end else begin
            ps = mq.size();
            nf = m_frames();
            ok = txfifo_wr_en && (txfifo_sof ? !m_in_frame : m_in_frame) && ps < 32;
            m_err = txfifo_wr_en && !ok;
            m_done = 0; m_abort = 0; m_dsc = 0;
            if (m_mode == 0) begin
               if (nf > 0) m_mode = 1;
            end else if (m_mode == 1) begin
               if (!trn_tdst_dsc_n) begin
                  m_abort = 1; m_mode = 2;
               end else if (ps > 0 && !trn_tdst_rdy_n) begin
                  w = mq.pop_front();
                  if (w[32]) begin m_done = 1; m_mode = 0; end
               end
            end else if (ps > 0) begin
               w = mq.pop_front();
               if (w[32]) m_mode = 0;
            end
            if (ok) begin
               mq.push_back({txfifo_sof, txfifo_eof, txfifo_data});
               m_in_frame = !txfifo_eof;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge sys_clk); #1; end
   endtask

   task automatic wr(input bit s, input bit e, input logic [31:0] d);
      txfifo_sof = s; txfifo_eof = e; txfifo_data = d; txfifo_wr_en = 1;
      tick(1);
      txfifo_wr_en = 0; txfifo_sof = 0; txfifo_eof = 0;
   endtask

   task automatic clr();
      xlog.delete(); n_done = 0; n_abort = 0; n_err = 0; n_dsc = 0;
   endtask

   initial begin
      tick(3);
      chk("rst_tsrc_rdy_n", trn_tsrc_rdy_n, 1);
      chk("rst_tsof_n", trn_tsof_n, 1);
      chk("rst_teof_n", trn_teof_n, 1);
      chk("rst_tsrc_dsc_n", trn_tsrc_dsc_n, 1);
      chk("rst_td", trn_td, 0);
      chk("rst_count", txfifo_count, 0);
      chk("rst_full", txfifo_full, 0);
      chk("rst_eof_rdy", txfifo_eof_rdy, 0);
      chk("rst_pulses", {txfifo_err, tx_done, tx_abort}, 0);
      sys_rst_n = 1;
      tick(1);

      clr();
      wr(1, 0, 32'h27); wr(0, 0, 32'h11111111); wr(0, 1, 32'h22222222);
      chk("t1_eof_rdy", txfifo_eof_rdy, 1);
      chk("t1_gap_rdy_n", trn_tsrc_rdy_n, 1);
      tick(1);
      chk("t1_first_rdy_n", trn_tsrc_rdy_n, 0);
      chk("t1_first_td", trn_td, 32'h27);
      chk("t1_first_sof_n", trn_tsof_n, 0);
      tick(6);
      chk("t1_nwords", xlog.size(), 3);
      chk("t1_w0", xlog[0], {2'b10, 32'h27});
      chk("t1_w1", xlog[1], {2'b00, 32'h11111111});
      chk("t1_w2", xlog[2], {2'b01, 32'h22222222});
      chk("t1_done", n_done, 1);
      chk("t1_count", txfifo_count, 0);

      clr();
      wr(1, 0, 32'h27); wr(0, 0, 32'h11111111); wr(0, 1, 32'h22222222);
      for (int i = 0; i < 14; i++) begin
         trn_tdst_rdy_n = (i % 2 == 0);
         tick(1);
      end
      trn_tdst_rdy_n = 0;
      tick(3);
      chk("t2_nwords", xlog.size(), 3);
      chk("t2_w0", xlog[0], {2'b10, 32'h27});
      chk("t2_w1", xlog[1], {2'b00, 32'h11111111});
      chk("t2_w2", xlog[2], {2'b01, 32'h22222222});
      chk("t2_done", n_done, 1);

      clr();
      wr(1, 0, 32'h30000000);
      for (int i = 1; i < 32; i++) begin
         wr(0, 0, 32'h30000000 + i);
         chk("t3_count", txfifo_count, i + 1);
         chk("t3_afull", txfifo_almost_full, (i + 1) >= 28);
      end
      chk("t3_full", txfifo_full, 1);
      wr(0, 0, 32'h3000DEAD);
      chk("t3_err", txfifo_err, 1);
      chk("t3_count_held", txfifo_count, 32);
      tick(1);
      chk("t3_err_end", txfifo_err, 0);
      chk("t3_nerr", n_err, 1);
      txfifo_flush = 1; tick(1); txfifo_flush = 0;
      chk("t3_flush_count", txfifo_count, 0);
      chk("t3_flush_dsc_n", trn_tsrc_dsc_n, 1);

      clr();
      trn_tdst_rdy_n = 1;
      wr(1, 0, 32'hA0000001);
      for (int i = 2; i < 5; i++) wr(0, 0, 32'hA0000000 + i);
      wr(0, 1, 32'hA0000005);
      wr(1, 0, 32'hB0000001); wr(0, 1, 32'hB0000002);
      tick(2);
      chk("t4_hold_rdy_n", trn_tsrc_rdy_n, 0);
      chk("t4_hold_td", trn_td, 32'hA0000001);
      trn_tdst_rdy_n = 0; tick(1);
      trn_tdst_dsc_n = 0; tick(1);
      trn_tdst_dsc_n = 1;
      chk("t4_abort", tx_abort, 1);
      tick(15);
      chk("t4_nwords", xlog.size(), 3);
      chk("t4_w0", xlog[0], {2'b10, 32'hA0000001});
      chk("t4_w1", xlog[1], {2'b10, 32'hB0000001});
      chk("t4_w2", xlog[2], {2'b01, 32'hB0000002});
      chk("t4_nabort", n_abort, 1);
      chk("t4_done", n_done, 1);
      chk("t4_count", txfifo_count, 0);

      clr();
      trn_tdst_rdy_n = 1;
      wr(1, 0, 32'h51); wr(0, 0, 32'h52); wr(0, 1, 32'h53);
      tick(2);
      chk("t5_send_rdy_n", trn_tsrc_rdy_n, 0);
      txfifo_flush = 1; tick(1); txfifo_flush = 0;
      chk("t5_dsc_n", trn_tsrc_dsc_n, 0);
      chk("t5_rdy_n", trn_tsrc_rdy_n, 1);
      chk("t5_count", txfifo_count, 0);
      chk("t5_eof_rdy", txfifo_eof_rdy, 0);
      tick(1);
      chk("t5_dsc_n_end", trn_tsrc_dsc_n, 1);
      trn_tdst_rdy_n = 0;
      wr(1, 0, 32'h55); wr(0, 1, 32'h56);
      tick(6);
      chk("t5_nwords", xlog.size(), 2);
      chk("t5_w0", xlog[0], {2'b10, 32'h55});
      chk("t5_w1", xlog[1], {2'b01, 32'h56});
      chk("t5_ndsc", n_dsc, 1);
      chk("t5_done", n_done, 1);

      clr();
      wr(0, 0, 32'h60);
      chk("t6_err_nosof", txfifo_err, 1);
      wr(1, 0, 32'h61);
      chk("t6_err_ok", txfifo_err, 0);
      wr(1, 0, 32'h62);
      chk("t6_err_2sof", txfifo_err, 1);
      chk("t6_count", txfifo_count, 1);
      chk("t6_eof_rdy", txfifo_eof_rdy, 0);
      wr(0, 1, 32'h63);
      tick(6);
      chk("t6_nwords", xlog.size(), 2);
      chk("t6_w0", xlog[0], {2'b10, 32'h61});
      chk("t6_w1", xlog[1], {2'b01, 32'h63});
      chk("t6_nerr", n_err, 2);

      clr();
      wr(1, 0, 32'h71); wr(0, 0, 32'h72);
      sys_rst_n = 0; tick(1); sys_rst_n = 1;
      chk("t7_count", txfifo_count, 0);
      chk("t7_dsc_n", trn_tsrc_dsc_n, 1);
      wr(0, 1, 32'h73);
      chk("t7_err_noframe", txfifo_err, 1);
      wr(1, 1, 32'h74);
      tick(5);
      chk("t7_nwords", xlog.size(), 1);
      chk("t7_w0", xlog[0], {2'b11, 32'h74});
      chk("t7_done", n_done, 1);
      chk("t7_ndsc", n_dsc, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
